audio_pcm_streamer: RTL and testbench
=====================================

Name: audio_pcm_streamer

Overview:
- CSR-fed stereo PCM source that buffers sample pairs in a FIFO and emits them as a packetised stream.
- Sits directly upstream of the audio output serializer and drives its d_* sink port.
- Each stereo frame is one 2-beat packet: left beat carries start_packet, right beat carries end_packet.
- Also inserts silence on underrun, so the serializer never starves.

Parameters:
- SAMPLE_W, 16: bits per channel sample; must be ≤ 16 because CSR DATA packs L[15:0], R[31:16].
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 stereo frames.

Ports:
- iCLK  in  1  single clock for CSR and stream.
- iRESETn  in  1  asynchronous active-low reset.
- iCSR_ADDRESS  in  3  register select.
- iCSR_READ  in  1  read strobe.
- oCSR_READ_DATA  out  32  read data, registered.
- iCSR_WRITE  in  1  write strobe.
- iCSR_WRITE_DATA  in  32  write data.
- oST_DATA  out  SAMPLE_W  stream sample.
- oST_VALID  out  1  stream valid.
- iST_READY  in  1  sink ready.
- oST_SOP  out  1  start of packet (left sample).
- oST_EOP  out  1  end of packet (right sample).

Behaviour:
- Reset (async assert, sync release): FIFO empty, CTRL=0, sticky flags=0, underrun count=0, state IDLE. oST_VALID=0, oST_SOP=0, oST_EOP=0, oST_DATA=0, oCSR_READ_DATA=0.
- CSR map:
  - addr0 CTRL (RW): bit0 EN; bit1 FLUSH, self-clearing, reads 0; bit2 ZFILL.
  - addr1 STATUS (RO): [DEPTH_LOG2:0] level; bit16 empty; bit17 full; bit18 OVF sticky; bit19 UNF sticky.
  - addr2 DATA (WO): push frame {R,L}.
  - addr3 UNDERRUN_CNT (RO): 16-bit saturating counter.
  - addr4 CLEAR (WO): bit0 clears OVF, bit1 clears UNF and the count.
  - Unmapped reads return 0.
- CSR read latency: 1 cycle; oCSR_READ_DATA holds until the next read.
- Push: a write to DATA while full is dropped and sets OVF. Level increments the cycle after the write.
- Stream handshake: a beat transfers when oST_VALID & iST_READY. While VALID=1 and READY=0, DATA, SOP and EOP are held stable.
- State machine:
  - IDLE: if EN & FIFO non-empty, pop a frame into the L/R holding register, go LEFT. Else if EN & ZFILL & empty, load zeros, increment UNDERRUN_CNT, set UNF, go LEFT. Otherwise stay in IDLE with VALID=0.
  - LEFT: VALID=1, SOP=1, data=L. On transfer go RIGHT.
  - RIGHT: VALID=1, EOP=1, data=R. On transfer, if another frame is available (or a zero-fill applies), load it and go LEFT in the same cycle (back-to-back, no bubble); else go IDLE.
- Clearing EN mid-packet: the current packet completes; no new frame starts.
- FLUSH: empties the FIFO next cycle. A packet in flight still completes from the holding register. A DATA write in the same cycle as FLUSH is discarded.
- Simultaneous push and pop: level unchanged, no flag change. A push when full with a same-cycle pop is accepted.
- Pointers wrap modulo depth. Level is DEPTH_LOG2+1 bits, so full = 2**DEPTH_LOG2.
- Counters: UNDERRUN_CNT saturates at 0xFFFF. CLEAR in the same cycle as a new underrun event: the event wins (flag stays set, count = 1).
- Reset mid-packet: outputs drop immediately; the frame is lost.

Test Plan:
- Reset, write CTRL=1, DATA=0xBBBB_AAAA, READY=1 → beats 0xAAAA(SOP=1,EOP=0) then 0xBBBB(SOP=0,EOP=1); level returns to 0; VALID=0 afterwards.
- Push 3 frames, READY=1 continuously → 6 consecutive valid beats, no bubble, SOP/EOP alternate.
- Hold READY=0 for 10 cycles during the left beat → DATA/SOP stable, level unchanged; release → normal completion.
- Push 17 frames with EN=0 (DEPTH_LOG2=4) → STATUS level=16, full=1, OVF=1; CLEAR bit0 → OVF=0.
- EN=1, ZFILL=1, FIFO empty, READY=1 for 3 packets → zero beats with SOP/EOP, UNDERRUN_CNT=3, UNF=1; push a frame → real data resumes at the next packet boundary.
- Mid right beat, write FLUSH with 4 frames queued → right beat completes, level=0, no further packets.

Source files
------------

// File: rtl/audio_pcm_streamer.sv
// audio_pcm_streamer: CSR-fed stereo PCM source. Frames written through the
// DATA register are queued in a small FIFO and played out as 2-beat packets
// (left beat with SOP, right beat with EOP) towards the audio serializer.
// When zero-fill is enabled, an empty FIFO produces silent frames instead of
// starving the sink, and each such frame is counted as an underrun.

module audio_pcm_streamer #(
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    input  logic [2:0]          iCSR_ADDRESS,
    input  logic                iCSR_READ,
    output logic [31:0]         oCSR_READ_DATA,
    input  logic                iCSR_WRITE,
    input  logic [31:0]         iCSR_WRITE_DATA,
    output logic [SAMPLE_W-1:0] oST_DATA,
    output logic                oST_VALID,
    input  logic                iST_READY,
    output logic                oST_SOP,
    output logic                oST_EOP
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int FRAME_W = 2 * SAMPLE_W;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DATA   = 3'd2;
    localparam logic [2:0] ADDR_UNDCNT = 3'd3;
    localparam logic [2:0] ADDR_CLEAR  = 3'd4;

    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;

    logic [FRAME_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_level;

    logic [SAMPLE_W-1:0]   r_holdL;
    logic [SAMPLE_W-1:0]   r_holdR;

    logic                  r_en;
    logic                  r_zfill;
    logic                  r_ovf;
    logic                  r_unf;
    logic [15:0]           r_underrunCnt;

    logic                  w_csrWrCtrl;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_pushAccept;
    logic                  w_pushDrop;
    logic                  w_clearOvf;
    logic                  w_clearUnf;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_frameAvail;
    logic                  w_zeroAvail;
    logic                  w_pop;
    logic                  w_loadZero;
    logic [31:0]           w_readData;

    // CSR write decode. A flush discards any push in the same cycle, and the
    // pop path is blocked while flushing so the FIFO really ends up empty.
    assign w_csrWrCtrl  = iCSR_WRITE && (iCSR_ADDRESS == ADDR_CTRL);
    assign w_flush      = w_csrWrCtrl && iCSR_WRITE_DATA[1];
    assign w_push       = iCSR_WRITE && (iCSR_ADDRESS == ADDR_DATA) && !w_flush;
    assign w_clearOvf   = iCSR_WRITE && (iCSR_ADDRESS == ADDR_CLEAR) && iCSR_WRITE_DATA[0];
    assign w_clearUnf   = iCSR_WRITE && (iCSR_ADDRESS == ADDR_CLEAR) && iCSR_WRITE_DATA[1];

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LEVEL_FULL);
    assign w_frameAvail = r_en && !w_empty && !w_flush;
    assign w_zeroAvail  = r_en && r_zfill && w_empty;

    // A full FIFO still accepts a push when a frame leaves in the same cycle.
    assign w_pushAccept = w_push && (!w_full || w_pop);
    assign w_pushDrop   = w_push && w_full && !w_pop;

    // Stream outputs decode straight from the state and holding register, so
    // they stay frozen for as long as the sink stalls.
    always_comb begin
        oST_VALID = (r_state != ST_IDLE);
        oST_SOP   = (r_state == ST_LEFT);
        oST_EOP   = (r_state == ST_RIGHT);
        oST_DATA  = '0;
        if (r_state == ST_LEFT) begin
            oST_DATA = r_holdL;
        end else if (r_state == ST_RIGHT) begin
            oST_DATA = r_holdR;
        end
    end

    // Next-state logic: a new frame (real or silent) is loaded from IDLE or at
    // the end of a right beat, which gives back-to-back packets with no bubble.
    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_loadZero  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_frameAvail) begin
                    w_pop       = 1'b1;
                    w_stateNext = ST_LEFT;
                end else if (w_zeroAvail) begin
                    w_loadZero  = 1'b1;
                    w_stateNext = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (iST_READY) begin
                    w_stateNext = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (iST_READY) begin
                    if (w_frameAvail) begin
                        w_pop       = 1'b1;
                        w_stateNext = ST_LEFT;
                    end else if (w_zeroAvail) begin
                        w_loadZero  = 1'b1;
                        w_stateNext = ST_LEFT;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register and L/R holding register for the packet in flight.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_state <= ST_IDLE;
            r_holdL <= '0;
            r_holdR <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_pop) begin
                r_holdL <= r_mem[r_rdPtr][SAMPLE_W-1:0];
                r_holdR <= r_mem[r_rdPtr][FRAME_W-1:SAMPLE_W];
            end else if (w_loadZero) begin
                r_holdL <= '0;
                r_holdR <= '0;
            end
        end
    end

    // FIFO storage; frames are stored as {R,L} exactly as written.
    always_ff @(posedge iCLK) begin
        if (w_pushAccept) begin
            r_mem[r_wrPtr] <= {iCSR_WRITE_DATA[16 +: SAMPLE_W], iCSR_WRITE_DATA[SAMPLE_W-1:0]};
        end
    end

    // FIFO pointers and level; pointers wrap naturally at the depth.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pushAccept && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_pushAccept) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Control bits; FLUSH is a pulse and never stored.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_en    <= 1'b0;
            r_zfill <= 1'b0;
        end else if (w_csrWrCtrl) begin
            r_en    <= iCSR_WRITE_DATA[0];
            r_zfill <= iCSR_WRITE_DATA[2];
        end
    end

    // Sticky flags and underrun counter; a new event beats a same-cycle clear.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
            r_underrunCnt <= '0;
        end else begin
            if (w_pushDrop) begin
                r_ovf <= 1'b1;
            end else if (w_clearOvf) begin
                r_ovf <= 1'b0;
            end
            if (w_loadZero) begin
                r_unf <= 1'b1;
                if (w_clearUnf) begin
                    r_underrunCnt <= 16'd1;
                end else if (r_underrunCnt != 16'hFFFF) begin
                    r_underrunCnt <= r_underrunCnt + 16'd1;
                end
            end else if (w_clearUnf) begin
                r_unf         <= 1'b0;
                r_underrunCnt <= '0;
            end
        end
    end

    // CSR read mux; write-only and unmapped addresses read as zero.
    always_comb begin
        w_readData = '0;
        unique case (iCSR_ADDRESS)
            ADDR_CTRL: begin
                w_readData[0] = r_en;
                w_readData[2] = r_zfill;
            end
            ADDR_STATUS: begin
                w_readData[DEPTH_LOG2:0] = r_level;
                w_readData[16]           = w_empty;
                w_readData[17]           = w_full;
                w_readData[18]           = r_ovf;
                w_readData[19]           = r_unf;
            end
            ADDR_UNDCNT: begin
                w_readData[15:0] = r_underrunCnt;
            end
            default: begin
                w_readData = '0;
            end
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oCSR_READ_DATA <= '0;
        end else if (iCSR_READ) begin
            oCSR_READ_DATA <= w_readData;
        end
    end

endmodule

// File: tb/tb_audio_pcm_streamer.sv
// Directed testbench for audio_pcm_streamer: each task drives one scenario and
// compares stream beats and CSR reads against hand-computed values.

module tb_audio_pcm_streamer;

    logic        iCLK = 1'b0;
    logic        iRESETn;
    logic [2:0]  iCSR_ADDRESS;
    logic        iCSR_READ;
    logic [31:0] oCSR_READ_DATA;
    logic        iCSR_WRITE;
    logic [31:0] iCSR_WRITE_DATA;
    logic [15:0] oST_DATA;
    logic        oST_VALID;
    logic        iST_READY;
    logic        oST_SOP;
    logic        oST_EOP;

    int checks = 0;
    int errors = 0;

    audio_pcm_streamer #(
        .SAMPLE_W   (16),
        .DEPTH_LOG2 (4)
    ) dut (
        .iCLK            (iCLK),
        .iRESETn         (iRESETn),
        .iCSR_ADDRESS    (iCSR_ADDRESS),
        .iCSR_READ       (iCSR_READ),
        .oCSR_READ_DATA  (oCSR_READ_DATA),
        .iCSR_WRITE      (iCSR_WRITE),
        .iCSR_WRITE_DATA (iCSR_WRITE_DATA),
        .oST_DATA        (oST_DATA),
        .oST_VALID       (oST_VALID),
        .iST_READY       (iST_READY),
        .oST_SOP         (oST_SOP),
        .oST_EOP         (oST_EOP)
    );

    // 100 MHz clock
    always #5 iCLK = ~iCLK;

    // Watchdog so a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic csrWrite(input logic [2:0] addr, input logic [31:0] data);
        @(negedge iCLK);
        iCSR_ADDRESS    = addr;
        iCSR_WRITE_DATA = data;
        iCSR_WRITE      = 1'b1;
        @(posedge iCLK);
        #1;
        iCSR_WRITE = 1'b0;
    endtask

    task automatic csrRead(input logic [2:0] addr, output logic [31:0] data);
        @(negedge iCLK);
        iCSR_ADDRESS = addr;
        iCSR_READ    = 1'b1;
        @(posedge iCLK);
        #1;
        iCSR_READ = 1'b0;
        data      = oCSR_READ_DATA;
    endtask

    // Returns at a falling edge where VALID is high
    task automatic waitValid(input string name);
        int n = 0;
        @(negedge iCLK);
        while (!oST_VALID && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        if (!oST_VALID) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got VALID=0, expected VALID=1 within 50 cycles", name);
        end
    endtask

    // Captures the next transferred beat and returns just after its clock edge
    task automatic waitBeat(input string name, output logic [15:0] d, output logic s, output logic e);
        int n = 0;
        @(negedge iCLK);
        while (!(oST_VALID && iST_READY) && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        if (!(oST_VALID && iST_READY)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no beat, expected a transfer within 50 cycles", name);
            d = 'x;
            s = 1'bx;
            e = 1'bx;
        end else begin
            d = oST_DATA;
            s = oST_SOP;
            e = oST_EOP;
            @(posedge iCLK);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        iRESETn = 1'b0; iCSR_ADDRESS = '0; iCSR_READ = 1'b0; iCSR_WRITE = 1'b0;
        iCSR_WRITE_DATA = '0; iST_READY = 1'b0;
        #12;
        checks++;
        if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA, oCSR_READ_DATA} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b sop=%b eop=%b data=%h rdata=%h, expected all 0",
                     oST_VALID, oST_SOP, oST_EOP, oST_DATA, oCSR_READ_DATA);
        end
        repeat (2) @(negedge iCLK);
        iRESETn = 1'b1;
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h, expected 00010000", rd);
        end
        csrRead(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_undcnt: got %h, expected 00000000", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] d; logic s, e; logic [31:0] rd;
        iST_READY = 1'b1;
        csrWrite(3'd0, 32'h1);
        csrWrite(3'd2, 32'hBBBB_AAAA);
        waitBeat("single_left", d, s, e);
        checks++;
        if ({d, s, e} !== {16'hAAAA, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_left: got data=%h sop=%b eop=%b, expected data=aaaa sop=1 eop=0", d, s, e);
        end
        waitBeat("single_right", d, s, e);
        checks++;
        if ({d, s, e} !== {16'hBBBB, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_right: got data=%h sop=%b eop=%b, expected data=bbbb sop=0 eop=1", d, s, e);
        end
        @(negedge iCLK);
        checks++;
        if (oST_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: got VALID=%b, expected 0", oST_VALID);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL single_status: got %h, expected 00010000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expD;
        iST_READY = 1'b1;
        csrWrite(3'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            csrWrite(3'd2, {16'h2200 + 16'(k), 16'h1100 + 16'(k)});
        end
        csrWrite(3'd0, 32'h1);
        waitValid("b2b");
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge iCLK);
            expD = (i % 2 == 1) ? 16'h2200 + 16'(i / 2) : 16'h1100 + 16'(i / 2);
            checks++;
            if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA} !== {1'b1, (i % 2 == 0), (i % 2 == 1), expD}) begin
                errors++;
                $display("[TB] FAIL b2b_beat%0d: got valid=%b sop=%b eop=%b data=%h, expected valid=1 sop=%b eop=%b data=%h",
                         i, oST_VALID, oST_SOP, oST_EOP, oST_DATA, (i % 2 == 0), (i % 2 == 1), expD);
            end
        end
        @(negedge iCLK);
        checks++;
        if (oST_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got VALID=%b, expected 0", oST_VALID);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d; logic s, e; logic [31:0] rd;
        iST_READY = 1'b0;
        csrWrite(3'd0, 32'h0);
        csrWrite(3'd2, 32'h4444_3333);
        csrWrite(3'd0, 32'h1);
        waitValid("bp");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge iCLK);
            checks++;
            if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA} !== {1'b1, 1'b1, 1'b0, 16'h3333}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b sop=%b eop=%b data=%h, expected valid=1 sop=1 eop=0 data=3333",
                         i, oST_VALID, oST_SOP, oST_EOP, oST_DATA);
            end
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL bp_status: got %h, expected 00010000", rd);
        end
        iST_READY = 1'b1;
        waitBeat("bp_left", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h3333, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bp_left: got data=%h sop=%b eop=%b, expected data=3333 sop=1 eop=0", d, s, e);
        end
        waitBeat("bp_right", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h4444, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bp_right: got data=%h sop=%b eop=%b, expected data=4444 sop=0 eop=1", d, s, e);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d; logic s, e; logic [31:0] rd;
        iST_READY = 1'b1;
        csrWrite(3'd0, 32'h0);
        for (int k = 0; k < 17; k++) begin
            csrWrite(3'd2, {16'h7000 + 16'(k), 16'h8000 + 16'(k)});
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0006_0010) begin
            errors++;
            $display("[TB] FAIL ovf_status: got %h, expected 00060010", rd);
        end
        csrRead(3'd7, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got %h, expected 00000000", rd);
        end
        csrWrite(3'd4, 32'h1);
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0002_0010) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %h, expected 00020010", rd);
        end
        csrWrite(3'd0, 32'h1);
        waitBeat("ovf_first", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h8000, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ovf_first: got data=%h sop=%b eop=%b, expected data=8000 sop=1 eop=0", d, s, e);
        end
        csrWrite(3'd0, 32'h2);
        repeat (10) @(negedge iCLK);
        checks++;
        if (oST_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_drain_idle: got VALID=%b, expected 0", oST_VALID);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL ovf_flushed: got %h, expected 00010000", rd);
        end
        csrRead(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL ctrl_flush_reads0: got %h, expected 00000000", rd);
        end
    endtask

    task automatic test_zero_fill();
        logic [15:0] d; logic s, e; logic [31:0] rd;
        iST_READY = 1'b1;
        csrWrite(3'd0, 32'h5);
        waitValid("zf");
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge iCLK);
            checks++;
            if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA} !== {1'b1, (i % 2 == 0), (i % 2 == 1), 16'h0}) begin
                errors++;
                $display("[TB] FAIL zf_beat%0d: got valid=%b sop=%b eop=%b data=%h, expected valid=1 sop=%b eop=%b data=0000",
                         i, oST_VALID, oST_SOP, oST_EOP, oST_DATA, (i % 2 == 0), (i % 2 == 1));
            end
            if (i == 4) begin
                iCSR_ADDRESS    = 3'd0;
                iCSR_WRITE_DATA = 32'h0;
                iCSR_WRITE      = 1'b1;
            end else begin
                iCSR_WRITE = 1'b0;
            end
        end
        @(negedge iCLK);
        iCSR_WRITE = 1'b0;
        checks++;
        if (oST_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zf_idle: got VALID=%b, expected 0", oST_VALID);
        end
        csrRead(3'd3, rd);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("[TB] FAIL zf_undcnt: got %h, expected 00000003", rd);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0009_0000) begin
            errors++;
            $display("[TB] FAIL zf_status: got %h, expected 00090000", rd);
        end
        // Real data takes over at the next packet boundary
        iST_READY = 1'b0;
        csrWrite(3'd0, 32'h5);
        waitValid("zf_resume");
        csrWrite(3'd2, 32'h6666_5555);
        iST_READY = 1'b1;
        waitBeat("zf_r0", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zf_resume0: got data=%h sop=%b eop=%b, expected data=0000 sop=1 eop=0", d, s, e);
        end
        waitBeat("zf_r1", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h0000, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zf_resume1: got data=%h sop=%b eop=%b, expected data=0000 sop=0 eop=1", d, s, e);
        end
        waitBeat("zf_r2", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h5555, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zf_resume2: got data=%h sop=%b eop=%b, expected data=5555 sop=1 eop=0", d, s, e);
        end
        waitBeat("zf_r3", d, s, e);
        checks++;
        if ({d, s, e} !== {16'h6666, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zf_resume3: got data=%h sop=%b eop=%b, expected data=6666 sop=0 eop=1", d, s, e);
        end
        csrWrite(3'd0, 32'h0);
        repeat (6) @(negedge iCLK);
        csrWrite(3'd4, 32'h2);
        csrRead(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zf_cnt_clear: got %h, expected 00000000", rd);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL zf_unf_clear: got %h, expected 00010000", rd);
        end
    endtask

    task automatic test_flush();
        logic [15:0] d; logic s, e; logic [31:0] rd;
        logic sawValid;
        iST_READY = 1'b0;
        csrWrite(3'd0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            csrWrite(3'd2, {16'hB000 + 16'(k), 16'hA000 + 16'(k)});
        end
        csrWrite(3'd0, 32'h1);
        waitValid("flush");
        iST_READY = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iST_READY = 1'b0;
        checks++;
        if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA} !== {1'b1, 1'b0, 1'b1, 16'hB000}) begin
            errors++;
            $display("[TB] FAIL flush_right: got valid=%b sop=%b eop=%b data=%h, expected valid=1 sop=0 eop=1 data=b000",
                     oST_VALID, oST_SOP, oST_EOP, oST_DATA);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL flush_level4: got %h, expected 00000004", rd);
        end
        csrWrite(3'd0, 32'h3);
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL flush_empty: got %h, expected 00010000", rd);
        end
        iST_READY = 1'b1;
        waitBeat("flush_finish", d, s, e);
        checks++;
        if ({d, s, e} !== {16'hB000, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL flush_finish: got data=%h sop=%b eop=%b, expected data=b000 sop=0 eop=1", d, s, e);
        end
        sawValid = 1'b0;
        repeat (10) begin
            @(negedge iCLK);
            if (oST_VALID) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_more: got VALID seen=%b, expected 0", sawValid);
        end
        csrRead(3'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL flush_ctrl: got %h, expected 00000001", rd);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] rd;
        iST_READY = 1'b0;
        csrWrite(3'd2, 32'hDDDD_CCCC);
        waitValid("rst_mid");
        #2;
        iRESETn = 1'b0;
        #1;
        checks++;
        if ({oST_VALID, oST_SOP, oST_EOP, oST_DATA} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got valid=%b sop=%b eop=%b data=%h, expected all 0",
                     oST_VALID, oST_SOP, oST_EOP, oST_DATA);
        end
        @(negedge iCLK);
        iRESETn = 1'b1;
        csrRead(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_ctrl: got %h, expected 00000000", rd);
        end
        csrRead(3'd1, rd);
        checks++;
        if (rd !== 32'h0001_0000) begin
            errors++;
            $display("[TB] FAIL rst_mid_status: got %h, expected 00010000", rd);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_zero_fill();
        test_flush();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
